// File: rtl/pool_window_feeder_if.sv
// Pixel-in / window-out bundle between the raster source, the window feeder and the pooling PE.
interface pool_window_feeder_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] win_data;
    logic              win_valid;
    logic              win_start;
    logic              win_last;
    logic              frame_done;
    logic              busy;

    modport master (
        input  start, in_data, in_valid,
        output in_ready, win_data, win_valid, win_start, win_last, frame_done, busy
    );

    modport slave (
        output start, in_data, in_valid,
        input  in_ready, win_data, win_valid, win_start, win_last, frame_done, busy
    );
endinterface

// File: rtl/pool_window_feeder.sv
// Reorders a raster feature map into serial 2x2 windows (TL,TR,BL,BR); first element 1 cycle after the BR pixel is taken.
// Input is stalled (in_ready=0) while a window streams out; the output never stalls.
module pool_window_feeder #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pool_window_feeder_if.master bus
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = $clog2(IMG_H) + 1;

    typedef enum logic [3:0] {
        IDLE, FILL, ACC0, ACC1, E0, E1, E2, E3, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col, col_p1;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] lbuf [IMG_W];
    logic [DATA_W-1:0] bl, br;
    logic              xfer, col_end, win_end, row_end;

    logic              in_ready_d, win_valid_d, win_last_d, frame_done_d, busy_d;
    logic [DATA_W-1:0] win_data_d;
    logic              in_ready_q, win_valid_q, win_last_q, frame_done_q, busy_q;
    logic [DATA_W-1:0] win_data_q;

    assign xfer    = bus.in_valid & in_ready_q;
    assign col_p1  = col + COL_W'(1);
    assign col_end = (col == COL_W'(IMG_W - 1));
    assign win_end = (col == COL_W'(IMG_W - 2));
    assign row_end = (row == ROW_W'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start)          state_nxt = FILL;
            FILL: if (xfer && col_end)    state_nxt = ACC0;
            ACC0: if (xfer)               state_nxt = ACC1;
            ACC1: if (xfer)               state_nxt = E0;
            E0:                           state_nxt = E1;
            E1:                           state_nxt = E2;
            E2:                           state_nxt = E3;
            E3: begin
                if (!win_end)             state_nxt = ACC0;
                else if (row_end)         state_nxt = DONE;
                else                      state_nxt = FILL;
            end
            DONE:                         state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and captured in flops, so every
    // port is driven straight from a register.
    always_comb begin
        in_ready_d   = 1'b0;
        win_valid_d  = 1'b0;
        win_last_d   = 1'b0;
        win_data_d   = '0;
        frame_done_d = 1'b0;
        busy_d       = (state_nxt != IDLE);
        case (state_nxt)
            FILL, ACC0, ACC1: in_ready_d = 1'b1;
            E0: begin win_valid_d = 1'b1; win_data_d = lbuf[col];    end
            E1: begin win_valid_d = 1'b1; win_data_d = lbuf[col_p1]; end
            E2: begin win_valid_d = 1'b1; win_data_d = bl;           end
            E3: begin win_valid_d = 1'b1; win_data_d = br; win_last_d = 1'b1; end
            DONE: frame_done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            win_data_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            in_ready_q   <= in_ready_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            win_data_q   <= win_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // Row counter briefly reaches IMG_H after the last window, then clears in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    col <= '0;
                    row <= '0;
                end
                FILL: if (xfer) begin
                    if (col_end) begin
                        col <= '0;
                        row <= row + ROW_W'(1);
                    end else begin
                        col <= col_p1;
                    end
                end
                E3: begin
                    if (!win_end) begin
                        col <= col + COL_W'(2);
                    end else begin
                        col <= '0;
                        row <= row + ROW_W'(1);
                    end
                end
                DONE: begin
                    col <= '0;
                    row <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && xfer) lbuf[col] <= bus.in_data;
        if (state == ACC0 && xfer) bl <= bus.in_data;
        if (state == ACC1 && xfer) br <= bus.in_data;
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_last   = win_last_q;
    assign bus.win_data   = win_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.win_start  = busy_q;
endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for the 4x4 configuration of the 2x2 window feeder.
module tb_pool_window_feeder;
    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;

    typedef struct packed {
        logic [N*DW-1:0] px;
        logic [N*DW-1:0] exp;
        logic            rnd;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pool_window_feeder_if #(.DATA_W(DW)) ifc ();
    pool_window_feeder #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_done, idle_bad, done_cyc, start_cyc;
    logic [DW-1:0] got[$];
    bit            lasts[$];
    vec_t          vecs[3];

    int ramp[16]     = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    int ramp_exp[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int sgn[16]      = '{-32768, 32767, 100, -200, -1, 0, 300, -400,
                         7, -7, 8, -8, -9, 9, -10, 10};
    int sgn_exp[16]  = '{-32768, 32767, -1, 0, 100, -200, 300, -400,
                         7, -7, -9, 9, 8, -8, -10, 10};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.win_valid) begin
            got.push_back(ifc.win_data);
            lasts.push_back(ifc.win_last);
        end else if (ifc.win_data !== '0 || ifc.win_last !== 1'b0) begin
            idle_bad++;
        end
        if (ifc.frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    function automatic logic [N*DW-1:0] pk(input int a[16]);
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = a[i][DW-1:0];
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},   32'(ifc.in_ready),   0);
        check({tag, "_win_valid"},  32'(ifc.win_valid),  0);
        check({tag, "_win_data"},   32'(ifc.win_data),   0);
        check({tag, "_win_start"},  32'(ifc.win_start),  0);
        check({tag, "_win_last"},   32'(ifc.win_last),   0);
        check({tag, "_frame_done"}, 32'(ifc.frame_done), 0);
        check({tag, "_busy"},       32'(ifc.busy),       0);
    endtask

    // mode 0: plain frame, 1: start pulse during E1 of first window, 2: reset during E2 (aborts)
    task automatic run_frame(input logic [N*DW-1:0] px, input bit rnd, input int mode);
        int  idx, vcnt, g;
        bit  v, abort;
        got.delete();
        lasts.delete();
        n_done    = 0;
        idle_bad  = 0;
        ifc.start    = 1'b1;
        ifc.in_valid = 1'b0;
        start_cyc    = cyc;
        step();
        ifc.start = 1'b0;
        idx = 0; vcnt = 0; g = 0; abort = 1'b0;
        while (idx < N && g < 600 && !abort) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ifc.in_valid = v;
            ifc.in_data  = v ? px[idx*DW +: DW] : 16'hdead;
            if (v && ifc.in_ready) idx++;
            step();
            g++;
            if (ifc.win_valid) vcnt++;
            ifc.start = (mode == 1 && ifc.win_valid && vcnt == 2);
            if (mode == 2 && ifc.win_valid && vcnt == 3) begin
                reset        = 1'b1;
                ifc.in_valid = 1'b0;
                step();
                check_idle("t5_reset_e2");
                reset = 1'b0;
                abort = 1'b1;
            end
        end
        ifc.in_valid = 1'b0;
        ifc.start    = 1'b0;
        if (!abort) begin
            if (idx != N) check("feed_timeout", idx, N);
            for (int k = 0; k < 100 && n_done == 0; k++) step();
            if (n_done == 0) check("done_timeout", 0, 1);
            step();
        end
    endtask

    task automatic check_frame(input int id, input logic [N*DW-1:0] exp, input bit timed);
        check($sformatf("v%0d_count", id), got.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < got.size()) begin
                check($sformatf("v%0d_elem%0d", id, i), 32'(got[i]), 32'(exp[i*DW +: DW]));
                check($sformatf("v%0d_last%0d", id, i), 32'(lasts[i]), 32'(i % 4 == 3));
            end
        end
        check($sformatf("v%0d_frame_done", id), n_done, 1);
        check($sformatf("v%0d_idle_zero", id), idle_bad, 0);
        if (timed) check($sformatf("v%0d_cycles", id), done_cyc - start_cyc + 1, 34);
        check($sformatf("v%0d_busy_after", id), 32'(ifc.busy), 0);
    endtask

    initial begin
        vecs[0] = '{px: pk(ramp), exp: pk(ramp_exp), rnd: 1'b0};
        vecs[1] = '{px: pk(ramp), exp: pk(ramp_exp), rnd: 1'b1};
        vecs[2] = '{px: pk(sgn),  exp: pk(sgn_exp),  rnd: 1'b0};

        reset        = 1'b1;
        ifc.start    = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 16'h1234;
        repeat (3) step();
        check_idle("t1_reset");
        ifc.start    = 1'b0;
        ifc.in_valid = 1'b0;
        reset        = 1'b0;
        step();

        for (int v = 0; v < 3; v++) begin
            run_frame(vecs[v].px, vecs[v].rnd, 0);
            check_frame(v, vecs[v].exp, !vecs[v].rnd);
        end

        run_frame(vecs[0].px, 1'b0, 1);
        check_frame(10, vecs[0].exp, 1'b1);
        run_frame(vecs[0].px, 1'b0, 0);
        check_frame(11, vecs[0].exp, 1'b1);

        run_frame(vecs[0].px, 1'b0, 2);
        run_frame(vecs[0].px, 1'b0, 0);
        check_frame(20, vecs[0].exp, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
